// File: rtl/reg_move_engine.sv
// reg_move_engine
//   Block-move initiator for the register bank. Executes one COPY, FILL or
//   SWAP command over a contiguous (modulo DEPTH) register range, driving the
//   bank's two combinational read ports and its single write port.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start             command strobe, only looked at while idle
//   op                00=COPY 01=FILL 10=SWAP 11=illegal
//   src, dst, count   source base, destination base, element count (0..DEPTH)
//   fill_data         value written by FILL
//   busy, done, error status; done/error are one-cycle pulses
//   rb_a, rb_b        bank read addresses, rb_dataA/rb_dataB the read data
//   rb_c, rb_dataC    bank write address / data, rb_write the write enable
//   checksum          (REG_MOVE_CHECKSUM_EN only) XOR of all data written
//                     by the current/last command
//
// Optional feature macro: REG_MOVE_CHECKSUM_EN
// All buses are declared MSB-at-index-0.

module reg_move_engine #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [0:1]        op,
  input  logic [0:ADDR_W-1] src,
  input  logic [0:ADDR_W-1] dst,
  input  logic [0:ADDR_W]   count,
  input  logic [0:DATA_W-1] fill_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [0:ADDR_W-1] rb_a,
  output logic [0:ADDR_W-1] rb_b,
  input  logic [0:DATA_W-1] rb_dataA,
  input  logic [0:DATA_W-1] rb_dataB,
  output logic [0:ADDR_W-1] rb_c,
  output logic [0:DATA_W-1] rb_dataC,
  output logic              rb_write
`ifdef REG_MOVE_CHECKSUM_EN
  ,
  output logic [0:DATA_W-1] checksum
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COPY,
    S_FILL,
    S_SWAP0,
    S_SWAP1,
    S_DONE
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

  state_t              state_reg;
  logic [ADDR_W:0]     idx_reg;
  logic [ADDR_W:0]     cnt_reg;
  logic [ADDR_W-1:0]   src_reg;
  logic [ADDR_W-1:0]   dst_reg;
  logic [DATA_W-1:0]   fill_reg;
  logic [DATA_W-1:0]   hold_reg;

  logic                cmd_ok;
  logic                accept;
  logic                last_elem;
  logic [ADDR_W:0]     idx_inc;
  logic [ADDR_W-1:0]   src_cur;
  logic [ADDR_W-1:0]   src_nxt;
  logic [ADDR_W-1:0]   dst_nxt;

  // Address sums are ADDR_W wide so the range wraps modulo DEPTH.
  always_comb begin
    cmd_ok    = (op != 2'b11) && (count <= DEPTH_C);
    accept    = (state_reg == S_IDLE) && start && cmd_ok;
    last_elem = (idx_reg == (cnt_reg - ONE_C));
    idx_inc   = idx_reg + ONE_C;
    src_cur   = src_reg + idx_reg[ADDR_W-1:0];
    src_nxt   = src_reg + idx_inc[ADDR_W-1:0];
    dst_nxt   = dst_reg + idx_inc[ADDR_W-1:0];
  end

  // Write data: COPY and the first SWAP cycle pass read port A straight
  // through so each element costs one cycle with no read pipeline.
  always_comb begin
    case (state_reg)
      S_COPY, S_SWAP0: rb_dataC = rb_dataA;
      S_FILL:          rb_dataC = fill_reg;
      S_SWAP1:         rb_dataC = hold_reg;
      default:         rb_dataC = '0;
    endcase
  end

  // Addresses and write enable are registered one step ahead: each
  // transition loads the bank controls for the element of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      idx_reg   <= '0;
      cnt_reg   <= '0;
      src_reg   <= '0;
      dst_reg   <= '0;
      fill_reg  <= '0;
      hold_reg  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      rb_a      <= '0;
      rb_b      <= '0;
      rb_c      <= '0;
      rb_write  <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            if (!cmd_ok) begin
              error <= 1'b1;
            end else if (count == '0) begin
              done      <= 1'b1;
              state_reg <= S_DONE;
            end else begin
              src_reg  <= src;
              dst_reg  <= dst;
              cnt_reg  <= count;
              fill_reg <= fill_data;
              idx_reg  <= '0;
              busy     <= 1'b1;
              rb_write <= 1'b1;
              case (op)
                2'b00: begin
                  state_reg <= S_COPY;
                  rb_a      <= src;
                  rb_c      <= dst;
                end
                2'b01: begin
                  state_reg <= S_FILL;
                  rb_c      <= dst;
                end
                default: begin
                  state_reg <= S_SWAP0;
                  rb_a      <= src;
                  rb_b      <= dst;
                  rb_c      <= dst;
                end
              endcase
            end
          end
        end
        S_COPY, S_FILL: begin
          if (last_elem) begin
            state_reg <= S_DONE;
            rb_write  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else begin
            idx_reg <= idx_inc;
            rb_a    <= src_nxt;
            rb_c    <= dst_nxt;
          end
        end
        S_SWAP0: begin
          // Capture the destination's old value before it is overwritten.
          hold_reg  <= rb_dataB;
          rb_c      <= src_cur;
          state_reg <= S_SWAP1;
        end
        S_SWAP1: begin
          if (last_elem) begin
            state_reg <= S_DONE;
            rb_write  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else begin
            idx_reg   <= idx_inc;
            rb_a      <= src_nxt;
            rb_b      <= dst_nxt;
            rb_c      <= dst_nxt;
            state_reg <= S_SWAP0;
          end
        end
        S_DONE: begin
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
          rb_write  <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef REG_MOVE_CHECKSUM_EN
  // Accept and a bank write never coincide (rb_write is low while idle).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum <= '0;
    end else if (accept) begin
      checksum <= '0;
    end else if (rb_write) begin
      checksum <= checksum ^ rb_dataC;
    end
  end
`endif

endmodule

// File: tb/tb_reg_move_engine.sv
// tb_reg_move_engine
//   Directed self-checking bench for reg_move_engine. Contains a behavioural
//   32x64 register bank (combinational reads, posedge write) plus a side
//   load port used to preload registers while the engine is idle.

module tb_reg_move_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [4:0]  src = '0;
  logic [4:0]  dst = '0;
  logic [5:0]  count = '0;
  logic [63:0] fill_data = '0;
  logic        busy, done, error, rb_write;
  logic [4:0]  rb_a, rb_b, rb_c;
  logic [63:0] rb_dataA, rb_dataB, rb_dataC;
`ifdef REG_MOVE_CHECKSUM_EN
  logic [63:0] checksum;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_move_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src(src), .dst(dst),
    .count(count), .fill_data(fill_data), .busy(busy), .done(done),
    .error(error), .rb_a(rb_a), .rb_b(rb_b), .rb_dataA(rb_dataA),
    .rb_dataB(rb_dataB), .rb_c(rb_c), .rb_dataC(rb_dataC), .rb_write(rb_write)
`ifdef REG_MOVE_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  // Register bank model
  logic [63:0] mem [0:31];
  logic        load_en = 1'b0;
  logic [4:0]  load_addr = '0;
  logic [63:0] load_data = '0;
  int          wr_count = 0;

  assign rb_dataA = mem[rb_a];
  assign rb_dataB = mem[rb_b];

  always @(posedge clk) begin
    if (load_en) begin
      mem[load_addr] <= load_data;
    end else if (rb_write === 1'b1) begin
      mem[rb_c] <= rb_dataC;
      wr_count  <= wr_count + 1;
    end
  end

  task automatic poke(input logic [4:0] a, input logic [63:0] d);
    @(negedge clk);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // Presents a command for one edge; returns at the negedge of the first
  // cycle after the start edge.
  task automatic issue(input logic [1:0] o, input logic [4:0] s, input logic [4:0] d,
                       input logic [5:0] c, input logic [63:0] f);
    @(negedge clk);
    op = o; src = s; dst = d; count = c; fill_data = f; start = 1'b1;
    $display("cmd op=%0d src=%0d dst=%0d count=%0d fill=%h", o, s, d, c, f);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Cycle k=1 is the current cycle; lat=0 means done never arrived.
  task automatic wait_done(output int lat, output int busyc);
    lat = 0; busyc = 0;
    for (int k = 1; k <= 100; k++) begin
      if (busy === 1'b1) busyc++;
      if (done === 1'b1) begin lat = k; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, error, rb_write} !== 4'b0000) begin
      failures++; $display("FAIL reset_flags got=%b exp=0000", {busy, done, error, rb_write});
    end
    checks++;
    if ({rb_a, rb_b, rb_c} !== 15'd0) begin
      failures++; $display("FAIL reset_addr got a=%0d b=%0d c=%0d exp 0", rb_a, rb_b, rb_c);
    end
    rst_n = 1'b1;
    @(negedge clk);
    $display("reset released");
  endtask

  task automatic test_fill;
    int lat, bc, w0;
    poke(5'd7, 64'h7777);
    for (int i = 4; i < 7; i++) poke(5'(i), 64'h0);
    w0 = wr_count;
    issue(2'b01, 5'd0, 5'd4, 6'd3, 64'hDEAD_BEEF_0000_0001);
    wait_done(lat, bc);
    checks++;
    if (lat !== 4) begin failures++; $display("FAIL fill_latency got=%0d exp=4", lat); end
    checks++;
    if (bc !== 3) begin failures++; $display("FAIL fill_busy got=%0d exp=3", bc); end
    checks++;
    if (wr_count - w0 !== 3) begin failures++; $display("FAIL fill_writes got=%0d exp=3", wr_count - w0); end
    for (int i = 4; i < 7; i++) begin
      checks++;
      if (mem[i] !== 64'hDEAD_BEEF_0000_0001) begin
        failures++; $display("FAIL fill_reg%0d got=%h exp=deadbeef00000001", i, mem[i]);
      end
    end
    checks++;
    if (mem[7] !== 64'h7777) begin failures++; $display("FAIL fill_reg7 got=%h exp=7777", mem[7]); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL fill_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_copy;
    int lat, bc;
    for (int i = 0; i < 4; i++) begin
      poke(5'(i), 64'(i + 1));
      poke(5'(16 + i), 64'h0);
    end
    issue(2'b00, 5'd0, 5'd16, 6'd4, 64'h0);
    wait_done(lat, bc);
    checks++;
    if (lat !== 5) begin failures++; $display("FAIL copy_latency got=%0d exp=5", lat); end
    checks++;
    if (bc !== 4) begin failures++; $display("FAIL copy_busy got=%0d exp=4", bc); end
    checks++;
    if (rb_write !== 1'b0) begin failures++; $display("FAIL copy_write_in_done got=%b exp=0", rb_write); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[16 + i] !== 64'(i + 1)) begin
        failures++; $display("FAIL copy_reg%0d got=%h exp=%h", 16 + i, mem[16 + i], 64'(i + 1));
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL copy_done_pulse got=%b exp=0", done); end
  endtask

  logic [63:0] sv_a [0:3] = '{64'hA000_0000_0000_000A, 64'hB000_0000_0000_000B,
                              64'hC000_0000_0000_000C, 64'hD000_0000_0000_000D};
  logic [63:0] sv_e [0:3] = '{64'hE000_0000_0000_000E, 64'hF000_0000_0000_000F,
                              64'h1234_0000_0000_0001, 64'h5678_0000_0000_0002};

  task automatic test_swap;
    int lat, bc, w0;
    logic [4:0] sa;
    for (int i = 0; i < 4; i++) begin
      sa = 5'(30 + i);
      poke(sa, sv_a[i]);
      poke(5'(2 + i), sv_e[i]);
    end
    w0 = wr_count;
    issue(2'b10, 5'd30, 5'd2, 6'd4, 64'h0);
    wait_done(lat, bc);
    checks++;
    if (lat !== 9) begin failures++; $display("FAIL swap_latency got=%0d exp=9", lat); end
    checks++;
    if (bc !== 8) begin failures++; $display("FAIL swap_busy got=%0d exp=8", bc); end
    checks++;
    if (wr_count - w0 !== 8) begin failures++; $display("FAIL swap_writes got=%0d exp=8", wr_count - w0); end
    for (int i = 0; i < 4; i++) begin
      sa = 5'(30 + i);
      checks++;
      if (mem[sa] !== sv_e[i]) begin
        failures++; $display("FAIL swap_src%0d got=%h exp=%h", sa, mem[sa], sv_e[i]);
      end
      checks++;
      if (mem[2 + i] !== sv_a[i]) begin
        failures++; $display("FAIL swap_dst%0d got=%h exp=%h", 2 + i, mem[2 + i], sv_a[i]);
      end
    end
  endtask

  task automatic test_illegal;
    int w0;
    poke(5'd8, 64'h88);
    w0 = wr_count;
    issue(2'b11, 5'd0, 5'd8, 6'd2, 64'h0);
    checks++;
    if ({error, busy} !== 2'b10) begin failures++; $display("FAIL op11_error got=%b exp=10", {error, busy}); end
    @(negedge clk);
    checks++;
    if ({error, busy, done} !== 3'b000) begin failures++; $display("FAIL op11_pulse got=%b exp=000", {error, busy, done}); end
    issue(2'b00, 5'd0, 5'd8, 6'd33, 64'h0);
    checks++;
    if ({error, busy} !== 2'b10) begin failures++; $display("FAIL count33_error got=%b exp=10", {error, busy}); end
    @(negedge clk);
    checks++;
    if ({error, busy, done} !== 3'b000) begin failures++; $display("FAIL count33_pulse got=%b exp=000", {error, busy, done}); end
    issue(2'b01, 5'd0, 5'd8, 6'd0, 64'hFFFF);
    checks++;
    if ({done, busy, error} !== 3'b100) begin failures++; $display("FAIL count0_done got=%b exp=100", {done, busy, error}); end
    repeat (3) @(negedge clk);
    checks++;
    if (wr_count - w0 !== 0) begin failures++; $display("FAIL illegal_writes got=%0d exp=0", wr_count - w0); end
    checks++;
    if (mem[8] !== 64'h88) begin failures++; $display("FAIL illegal_reg8 got=%h exp=88", mem[8]); end
  endtask

  task automatic test_back_to_back;
    int lat, bc, w0;
    for (int i = 0; i < 4; i++) poke(5'(20 + i), 64'h0);
    w0 = wr_count;
    issue(2'b00, 5'd16, 5'd20, 6'd4, 64'h0);
    // Competing command while busy
    op = 2'b01; dst = 5'd8; count = 6'd1; fill_data = 64'hFFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bc);
    checks++;
    if (lat !== 4) begin failures++; $display("FAIL busy_ignore_latency got=%0d exp=4", lat); end
    // Competing command in the done cycle
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) begin
      checks++;
      if ({busy, rb_write} !== 2'b00) begin
        failures++; $display("FAIL done_start_ignored got=%b exp=00", {busy, rb_write});
      end
      @(negedge clk);
    end
    checks++;
    if (wr_count - w0 !== 4) begin failures++; $display("FAIL b2b_writes got=%0d exp=4", wr_count - w0); end
    checks++;
    if (mem[8] !== 64'h88) begin failures++; $display("FAIL b2b_reg8 got=%h exp=88", mem[8]); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[20 + i] !== 64'(i + 1)) begin
        failures++; $display("FAIL b2b_reg%0d got=%h exp=%h", 20 + i, mem[20 + i], 64'(i + 1));
      end
    end
  endtask

  task automatic test_full_range;
    int lat, bc, w0;
    w0 = wr_count;
    issue(2'b01, 5'd0, 5'd10, 6'd32, 64'h5A5A_5A5A_5A5A_5A5A);
    wait_done(lat, bc);
    checks++;
    if (lat !== 33) begin failures++; $display("FAIL full_latency got=%0d exp=33", lat); end
    checks++;
    if (wr_count - w0 !== 32) begin failures++; $display("FAIL full_writes got=%0d exp=32", wr_count - w0); end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (mem[i] !== 64'h5A5A_5A5A_5A5A_5A5A) begin
        failures++; $display("FAIL full_reg%0d got=%h exp=5a5a5a5a5a5a5a5a", i, mem[i]);
      end
    end
  endtask

  task automatic test_reset_mid_copy;
    int w0;
    for (int i = 0; i < 8; i++) poke(5'(i), 64'(100 + i));
    w0 = wr_count;
    issue(2'b00, 5'd0, 5'd16, 6'd8, 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, rb_write} !== 2'b00) begin failures++; $display("FAIL midreset_outputs got=%b exp=00", {busy, rb_write}); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (wr_count - w0 !== 2) begin failures++; $display("FAIL midreset_writes got=%0d exp=2", wr_count - w0); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (mem[16 + i] !== ((i < 2) ? 64'(100 + i) : 64'h5A5A_5A5A_5A5A_5A5A)) begin
        failures++; $display("FAIL midreset_reg%0d got=%h", 16 + i, mem[16 + i]);
      end
    end
  endtask

`ifdef REG_MOVE_CHECKSUM_EN
  task automatic test_checksum;
    int lat, bc;
    issue(2'b01, 5'd0, 5'd24, 6'd2, 64'h1);
    wait_done(lat, bc);
    checks++;
    if (checksum !== 64'h0) begin failures++; $display("FAIL csum_fill got=%h exp=0", checksum); end
    poke(5'd0, 64'h1);
    poke(5'd1, 64'h2);
    issue(2'b00, 5'd0, 5'd26, 6'd2, 64'h0);
    wait_done(lat, bc);
    checks++;
    if (checksum !== 64'h3) begin failures++; $display("FAIL csum_copy got=%h exp=3", checksum); end
    repeat (2) @(negedge clk);
    checks++;
    if (checksum !== 64'h3) begin failures++; $display("FAIL csum_hold got=%h exp=3", checksum); end
  endtask
`endif

  initial begin
    test_reset;
    test_fill;
    test_copy;
    test_swap;
    test_illegal;
    test_back_to_back;
    test_full_range;
    test_reset_mid_copy;
`ifdef REG_MOVE_CHECKSUM_EN
    test_checksum;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
